alu_accumulator: RTL and testbench



---
 rtl/alu_pkg.sv | 58 +++++
 rtl/alu_core.sv | 23 ++
 rtl/alu_accumulator.sv | 79 +++++++
 tb/tb_alu_accumulator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and the ALU evaluation function for the accumulator ALU.
// alu_eval works on MAX_W-bit containers; callers pass their real width (WIDTH < MAX_W).
package alu_pkg;

    localparam int MAX_W = 64;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic {ST_RUN, ST_ERROR} state_t;

    // Returns {err, result}; result is width+1 bits wide in the low end, upper bits zero.
    function automatic logic [MAX_W+1:0] alu_eval(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic [2:0]       op,
        input logic             saturate,
        input int unsigned      width
    );
        logic [MAX_W:0] ea;
        logic [MAX_W:0] eb;
        logic [MAX_W:0] res;
        logic [MAX_W:0] ones_w;
        logic [MAX_W:0] ones_w1;
        logic           err;
        ea      = {1'b0, a};
        eb      = {1'b0, b};
        ones_w  = ((MAX_W+1)'(1) << width) - (MAX_W+1)'(1);
        ones_w1 = {ones_w[MAX_W-1:0], 1'b1};
        err     = 1'b0;
        case (op)
            OP_ADD: begin
                res = ea + eb;
                // Carry bit is the one set in ones_w1 but not in ones_w.
                if (|(res & ones_w1 & ~ones_w)) begin
                    err = 1'b1;
                    res = saturate ? ones_w : '0;
                end
            end
            OP_SUB:  res = (ea - eb) & ones_w1;
            OP_SHL:  res = ea << 1;
            OP_SHR:  res = ea >> 1;
            OP_AND:  res = ea & eb;
            OP_OR:   res = ea | eb;
            OP_XOR:  res = ea ^ eb;
            OP_NOT:  res = ~ea & ones_w;
            default: res = '0;
        endcase
        return {err, res};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU slice around alu_pkg::alu_eval.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH:0]   result,
    output logic             err
);

    logic [MAX_W+1:0] eval;
    logic             unused_hi;

    assign eval      = alu_eval(MAX_W'(a), MAX_W'(b), op, SATURATE, WIDTH);
    assign result    = eval[WIDTH:0];
    assign err       = eval[MAX_W+1];
    assign unused_hi = ^eval[MAX_W:WIDTH+1];

endmodule

// File: rtl/alu_accumulator.sv
// Registered ALU with accumulator, valid/ready on both sides and a sticky error state.
module alu_accumulator
    import alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic             acc_clr,
    input  logic             err_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             err,
    output logic [CNT_W-1:0] ops_done
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH:0]   core_result;
    logic             core_err;
    logic             accept;

    assign opa = use_acc ? acc : x;

    alu_core #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_core (
        .a      (opa),
        .b      (y),
        .op     (op),
        .result (core_result),
        .err    (core_err)
    );

    // NOTE: acc_clr blocks acceptance so the clear and an accumulate never race on acc.
    assign in_ready = (state == ST_RUN) && !acc_clr && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign err      = (state == ST_ERROR);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            result    <= '0;
            acc       <= '0;
            ops_done  <= '0;
        end else begin
            if (accept) begin
                result    <= core_result;
                out_valid <= 1'b1;
                acc       <= core_result[WIDTH-1:0];
                ops_done  <= ops_done + CNT_W'(1);
                if (core_err) begin
                    state <= ST_ERROR;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (acc_clr) begin
                acc <= '0;
            end

            if (state == ST_ERROR && err_clr) begin
                state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed, table-driven bench for alu_accumulator (WIDTH=16, SATURATE=0, CNT_W=8).
module tb_alu_accumulator;
    import alu_pkg::*;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [2:0]       op;
    logic             use_acc;
    logic             acc_clr;
    logic             err_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             err;
    logic [CNT_W-1:0] ops_done;

    int total;
    int passed;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] exp_res;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    alu_accumulator #(.WIDTH(WIDTH), .SATURATE(1'b0), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .op        (op),
        .use_acc   (use_acc),
        .acc_clr   (acc_clr),
        .err_clr   (err_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic do_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic ua);
        int n;
        op = o; x = a; y = b; use_acc = ua; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready wait", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; passed = 0;
        clear = 1'b1; in_valid = 1'b0; x = '0; y = '0; op = OP_ADD;
        use_acc = 1'b0; acc_clr = 1'b0; err_clr = 1'b0; out_ready = 1'b1;

        vecs[0] = '{OP_ADD, 16'h00E1, 16'h0B01, 17'h00BE2, 1'b0};
        vecs[1] = '{OP_SUB, 16'h00E1, 16'h0B01, 17'h1F5E0, 1'b0};
        vecs[2] = '{OP_SHL, 16'h8001, 16'h00FF, 17'h10002, 1'b0};
        vecs[3] = '{OP_SHR, 16'h8001, 16'h00FF, 17'h04000, 1'b0};
        vecs[4] = '{OP_AND, 16'h8001, 16'h00FF, 17'h00001, 1'b0};
        vecs[5] = '{OP_OR,  16'h8001, 16'h00FF, 17'h080FF, 1'b0};
        vecs[6] = '{OP_XOR, 16'h8001, 16'h00FF, 17'h080FE, 1'b0};
        vecs[7] = '{OP_NOT, 16'h8001, 16'h00FF, 17'h07FFE, 1'b0};
        vecs[8] = '{OP_SUB, 16'h1234, 16'h1234, 17'h00000, 1'b0};
        vecs[9] = '{OP_ADD, 16'h8000, 16'h7FFF, 17'h0FFFF, 1'b0};

        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset err", err, 0);
        check("reset ops_done", ops_done, 0);
        clear = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            check($sformatf("vec%0d result", i), result, vecs[i].exp_res);
            check($sformatf("vec%0d err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d ops_done", i), ops_done, i + 1);
        end

        // Overflow, sticky error, recovery.
        do_op(OP_ADD, 16'h0001, 16'hFFFF, 1'b0);
        check("ovf result", result, 17'h00000);
        check("ovf err", err, 1);
        check("ovf ops_done", ops_done, 11);
        op = OP_OR; x = 16'h0F0F; y = 16'h0001; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("err in_ready", in_ready, 0);
        check("err drained", out_valid, 0);
        check("err no accept", ops_done, 11);
        check("err sticky", err, 1);
        in_valid = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr err", err, 0);
        check("err_clr in_ready", in_ready, 1);

        // Accumulate.
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        do_op(OP_ADD, 16'h1111, 16'h0005, 1'b1);
        check("acc1", result, 17'h00005);
        do_op(OP_ADD, 16'h1111, 16'h0005, 1'b1);
        check("acc2", result, 17'h0000A);
        do_op(OP_ADD, 16'h1111, 16'h0005, 1'b1);
        check("acc3", result, 17'h0000F);
        acc_clr = 1'b1; op = OP_ADD; use_acc = 1'b1; y = 16'h0005; in_valid = 1'b1;
        #1;
        check("acc_clr in_ready", in_ready, 0);
        @(negedge clk);
        acc_clr = 1'b0;
        check("acc_clr no accept", ops_done, 14);
        #1;
        check("acc_clr released", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("acc after clr", result, 17'h00005);
        check("acc ops_done", ops_done, 15);

        // Backpressure.
        @(negedge clk);
        check("bp drained", out_valid, 0);
        out_ready = 1'b0;
        do_op(OP_ADD, 16'h0010, 16'h0020, 1'b0);
        check("bp first", result, 17'h00030);
        op = OP_XOR; x = 16'h00F0; y = 16'h000F; use_acc = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bp%0d result", k), result, 17'h00030);
            check($sformatf("bp%0d in_ready", k), in_ready, 0);
            check($sformatf("bp%0d out_valid", k), out_valid, 1);
            @(negedge clk);
        end
        check("bp ops_done", ops_done, 16);
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp second", result, 17'h000FF);
        check("bp second ops", ops_done, 17);
        check("bp second valid", out_valid, 1);

        // Async clear with a pending, non-zero result.
        out_ready = 1'b0;
        #2 clear = 1'b1;
        #1;
        check("clrA out_valid", out_valid, 0);
        check("clrA result", result, 0);
        check("clrA ops_done", ops_done, 0);
        @(negedge clk);
        clear = 1'b0;
        out_ready = 1'b1;
        do_op(OP_ADD, 16'h1234, 16'h0003, 1'b1);
        check("clrA acc zero", result, 17'h00003);
        check("clrA ops restart", ops_done, 1);

        // Async clear while in ERROR with a pending result.
        @(negedge clk);
        out_ready = 1'b0;
        do_op(OP_ADD, 16'h0001, 16'hFFFF, 1'b0);
        check("clrB err set", err, 1);
        check("clrB valid set", out_valid, 1);
        #2 clear = 1'b1;
        #1;
        check("clrB err", err, 0);
        check("clrB out_valid", out_valid, 0);
        check("clrB ops_done", ops_done, 0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("clrB in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
